// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, load capture, timeout/misalign error.
// Latency >= 3 cycles per memory op (detect, ACCESS, DONE); stall freezes upstream until DONE, held forever in ERR.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALUOut_MEM,
    input  logic [31:0] RD2_WD_MEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] RD_MEM,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rd_q, rd_d;

    logic access;
    logic misaligned;
    logic timeout;

    assign access     = MemRead_MEM | MemWrite_MEM;
    assign misaligned = ALUOut_MEM[1:0] != 2'b00;
    assign timeout    = !mem_ack && (cnt_q == LAST_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rd_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = misaligned ? ERR : ACCESS;
            ACCESS:  if (mem_ack) state_d = DONE;
                     else if (timeout) state_d = ERR;
            DONE:    state_d = IDLE;
            default: state_d = ERR;
        endcase
    end

    // Request/data registers; mem_ack wins over the timeout when both land together.
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    req_d   = 1'b1;
                    we_d    = MemWrite_MEM;
                    addr_d  = ALUOut_MEM;
                    wdata_d = RD2_WD_MEM;
                    cnt_d   = '0;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) rd_d = mem_rdata;
                end else if (timeout) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: ;
        endcase
    end

    // Gated by reset so the pipeline is released the instant reset asserts.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:       stall = access;
                ACCESS,
                ERR:        stall = 1'b1;
                default:    stall = 1'b0;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign RD_MEM    = rd_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-instruction timeline model feeding an expected-output queue.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [31:0] ALUOut_MEM, RD2_WD_MEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata, RD_MEM;
    logic        stall, mem_err;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .ALUOut_MEM(ALUOut_MEM), .RD2_WD_MEM(RD2_WD_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .RD_MEM(RD_MEM), .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Architectural view of what the block must be holding.
    logic [31:0] m_addr, m_wdata, m_rd;
    logic        m_we, m_err;

    // Observation counters, only ever read as differences by the driver.
    int          req_cycles = 0;
    int          stall_cycles = 0;
    logic        prev_req = 1'b0;
    logic [31:0] req_log[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            chk1 ("stall",     stall,     e_cur.stall);
            chk1 ("mem_req",   mem_req,   e_cur.req);
            chk1 ("mem_we",    mem_we,    e_cur.we);
            chk1 ("mem_err",   mem_err,   e_cur.err);
            chk32("mem_addr",  mem_addr,  e_cur.addr);
            chk32("mem_wdata", mem_wdata, e_cur.wdata);
            chk32("RD_MEM",    RD_MEM,    e_cur.rd);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mem_req) req_cycles++;
            if (stall) stall_cycles++;
            if (mem_req && !prev_req) req_log.push_back(mem_addr);
        end
        prev_req = mem_req;
    end

    task automatic push_exp(input logic s, input logic r);
        exp_t e;
        e.stall = s;     e.req = r;         e.we = m_we;   e.err = m_err;
        e.addr  = m_addr; e.wdata = m_wdata; e.rd = m_rd;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nonmem();
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        ALUOut_MEM = $urandom; RD2_WD_MEM = $urandom;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        push_exp(1'b0, 1'b0);
        step();
    endtask

    // dly: ACCESS cycle index carrying mem_ack (>= TIMEOUT never acks); abort: stop before that ACCESS cycle.
    task automatic mem_instr(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int dly, input logic [31:0] ld_data, input int abort);
        MemRead_MEM = rd; MemWrite_MEM = wr; ALUOut_MEM = a; RD2_WD_MEM = wd;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        push_exp(1'b1, 1'b0);
        step();
        if (a[1:0] != 2'b00) begin
            m_err = 1'b1;
            return;
        end
        m_addr = a; m_we = wr; m_wdata = wd;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (i == abort) return;
            mem_ack   = (i == dly);
            mem_rdata = (i == dly) ? ld_data : $urandom;
            push_exp(1'b1, 1'b1);
            step();
            if (i == dly) begin
                if (!wr) m_rd = ld_data;
                mem_ack = 1'($urandom); mem_rdata = $urandom;
                push_exp(1'b0, 1'b0);
                step();
                return;
            end
        end
        m_err = 1'b1;
    endtask

    task automatic err_cycles(input int n, input logic force_ack);
        for (int i = 0; i < n; i++) begin
            MemRead_MEM = 1'($urandom); MemWrite_MEM = 1'($urandom);
            ALUOut_MEM = $urandom; RD2_WD_MEM = $urandom;
            mem_ack = force_ack | 1'($urandom); mem_rdata = $urandom;
            push_exp(1'b1, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk1("async_req",   mem_req, 1'b0);
        chk1("async_stall", stall,   1'b0);
        chk1("async_err",   mem_err, 1'b0);
        step();
        m_addr = 32'b0; m_wdata = 32'b0; m_rd = 32'b0; m_we = 1'b0; m_err = 1'b0;
        chk32("rst_addr", mem_addr, 32'b0);
        chk32("rst_rd",   RD_MEM,   32'b0);
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; mem_ack = 1'b0;
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int r0, s0, l0, k, dly;
        logic [31:0] a;
        logic rd, wr;

        reset = 1'b0;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; ALUOut_MEM = 32'b0; RD2_WD_MEM = 32'b0;
        mem_ack = 1'b0; mem_rdata = 32'b0;
        m_addr = 32'b0; m_wdata = 32'b0; m_rd = 32'b0; m_we = 1'b0; m_err = 1'b0;
        step(); step();
        chk1 ("init_req",   mem_req,  1'b0);
        chk1 ("init_we",    mem_we,   1'b0);
        chk1 ("init_err",   mem_err,  1'b0);
        chk1 ("init_stall", stall,    1'b0);
        chk32("init_addr",  mem_addr, 32'b0);
        chk32("init_rd",    RD_MEM,   32'b0);
        reset = 1'b1;
        nonmem(); nonmem();

        // Load acked in its first ACCESS cycle
        r0 = req_cycles; s0 = stall_cycles;
        mem_instr(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, -1);
        chkn ("load_req_cycles",   req_cycles - r0,   1);
        chkn ("load_stall_cycles", stall_cycles - s0, 2);
        chk32("load_rd",   RD_MEM,   32'hDEADBEEF);
        chk32("load_addr", mem_addr, 32'h40);

        // Store acked after 4 wait cycles
        r0 = req_cycles; s0 = stall_cycles;
        mem_instr(1'b0, 1'b1, 32'h80, 32'h12345678, 4, 32'hFFFF0000, -1);
        chkn ("store_req_cycles",   req_cycles - r0,   5);
        chkn ("store_stall_cycles", stall_cycles - s0, 6);
        chk1 ("store_we",    mem_we,    1'b1);
        chk32("store_wdata", mem_wdata, 32'h12345678);
        chk32("store_rd",    RD_MEM,    32'hDEADBEEF);

        // Back-to-back loads around a non-memory instruction
        l0 = req_log.size(); s0 = stall_cycles;
        mem_instr(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hA5A5_0010, -1);
        nonmem();
        mem_instr(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'hA5A5_0014, -1);
        chkn("b2b_req_count", req_log.size() - l0, 2);
        if (req_log.size() - l0 == 2) begin
            chk32("b2b_first",  req_log[l0],     32'h10);
            chk32("b2b_second", req_log[l0 + 1], 32'h14);
        end
        chkn("b2b_stall_cycles", stall_cycles - s0, 4);

        // Ack coinciding with the last wait cycle must still complete
        mem_instr(1'b1, 1'b1, 32'hC0, 32'h5555_AAAA, TIMEOUT - 1, 32'h0, -1);
        chk1("ack_beats_timeout", mem_err, 1'b0);

        // Timeout with ack held low, then late acks
        r0 = req_cycles;
        mem_instr(1'b1, 1'b0, 32'h100, 32'h0, TIMEOUT, 32'h0, -1);
        err_cycles(3, 1'b1);
        chkn("timeout_req_cycles", req_cycles - r0, TIMEOUT);
        chk1("timeout_err",   mem_err, 1'b1);
        chk1("timeout_stall", stall,   1'b1);
        do_reset();

        // Misaligned load
        r0 = req_cycles;
        mem_instr(1'b1, 1'b0, 32'h42, 32'h0, 0, 32'h0, -1);
        err_cycles(2, 1'b0);
        chkn("misalign_req_cycles", req_cycles - r0, 0);
        chk1("misalign_err", mem_err, 1'b1);
        do_reset();
        chk1("misalign_cleared", mem_err, 1'b0);

        // Reset in the middle of an access, then a normal load
        mem_instr(1'b1, 1'b0, 32'h200, 32'h0, 10, 32'h0, 3);
        do_reset();
        mem_instr(1'b1, 1'b0, 32'h204, 32'h0, 1, 32'hCAFE_F00D, -1);
        chk32("post_reset_load", RD_MEM, 32'hCAFE_F00D);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            k   = $urandom_range(0, 99);
            a   = $urandom & 32'hFFFF_FFFC;
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 4);
            if (k < 35) begin
                nonmem();
            end else if (k < 85) begin
                rd = (k < 55) || (k >= 75);
                wr = (k >= 55);
                mem_instr(rd, wr, a, $urandom, dly, $urandom, -1);
            end else if (k < 90) begin
                wr = 1'($urandom);
                mem_instr(!wr, wr, a | 32'($urandom_range(1, 3)), $urandom, dly, $urandom, -1);
                err_cycles($urandom_range(1, 3), 1'b0);
                do_reset();
            end else if (k < 94) begin
                mem_instr(1'b1, 1'($urandom), a, $urandom, TIMEOUT, $urandom, -1);
                err_cycles($urandom_range(1, 3), 1'b0);
                do_reset();
            end else begin
                mem_instr(1'($urandom), 1'b1, a, $urandom, TIMEOUT, $urandom, $urandom_range(0, TIMEOUT - 1));
                do_reset();
            end
        end

        nonmem();
        @(negedge clk);
        #1;
        chkn("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences every data-memory access of the MEM stage for a memory with variable latency and a req/ack interface. It decodes MemRead/MemWrite from the EX_MEM control outputs and drives the memory handshake. While an access is in flight it asserts a pipeline stall that freezes PC, IF_ID, ID_EX and EX_MEM. It returns held load data to the MEM_WB register and flags timeouts and misaligned accesses.

Parameters:
TIMEOUT, 15, max cycles in ACCESS without mem_ack before error (1..2^CW-1)
CW, 4, width of the wait counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
MemRead_MEM  input  1  MEM_MEM[2] of EX_MEM
MemWrite_MEM  input  1  MEM_MEM[1] of EX_MEM
ALUOut_MEM  input  32  byte address
RD2_WD_MEM  input  32  store data
mem_req  output  1  request to data memory, registered
mem_we  output  1  1 = write, registered
mem_addr  output  32  registered address
mem_wdata  output  32  registered store data
mem_ack  input  1  memory completion, one-cycle pulse or level
mem_rdata  input  32  load data, valid with mem_ack
RD_MEM  output  32  captured load data to MEM_WB
stall  output  1  freeze upstream pipeline registers, bubble MEM_WB
mem_err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_req, mem_we, mem_err, wait counter = 0; mem_addr, mem_wdata, RD_MEM = 32'b0. mem_req drops immediately, even mid-access.
- States: IDLE, ACCESS, DONE, ERR (2-bit encoding).
- access = MemRead_MEM | MemWrite_MEM. If both are 1, the access is a write.
- stall is combinational: 1 when (IDLE & access) or ACCESS or ERR; 0 in DONE and when IDLE has no access.
- IDLE: with access and ALUOut_MEM[1:0]==0, latch addr, wdata and we=MemWrite_MEM, set mem_req=1, clear counter, go to ACCESS. With access and misalignment, go to ERR without issuing mem_req. mem_ack is ignored.
- ACCESS: mem_req held at 1 with stable addr/we/wdata.
  - When mem_ack=1 is sampled: mem_req<=0. On a read, RD_MEM<=mem_rdata. Go to DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without ack, then mem_req<=0, mem_err<=1, go to ERR. An ack in the same cycle wins over the timeout.
- DONE: one cycle, stall=0, so the pipeline advances and MEM_WB captures RD_MEM. Access inputs are ignored, because they still belong to the completed instruction. Always goes to IDLE.
- ERR: stall=1 and mem_err=1 until reset. mem_ack is ignored.
- RD_MEM changes only on a read completion. Writes and errors leave it unchanged.
- Latency: minimum 3 cycles per memory instruction (detect, ACCESS with ack in the first cycle, DONE). Non-memory instructions pass with zero added cycles.
- Back-to-back memory instructions: the second is detected in the IDLE cycle after DONE. There is no lost or duplicated request.

Test Plan:
- Load, ack in first ACCESS cycle: ALUOut_MEM=0x40, MemRead=1, mem_rdata=0xDEADBEEF -> mem_req high 1 cycle with mem_addr=0x40 and mem_we=0; stall high 2 cycles; RD_MEM=0xDEADBEEF in DONE.
- Store, ack after 4 wait cycles: addr 0x80, data 0x12345678 -> mem_we=1, mem_req high 5 cycles, stall high 6 cycles, RD_MEM unchanged.
- Timeout (TIMEOUT=15) with mem_ack held 0 -> mem_req drops after 15 cycles, mem_err=1, stall stays 1. A late ack has no effect.
- Misaligned load at 0x42 -> mem_req never asserts, ERR next cycle, mem_err=1. A later reset=0 clears everything.
- Reset pulled low while in ACCESS -> mem_req, stall and mem_err are 0 in the same cycle, without waiting for a clock edge. After release, the next load proceeds normally.
- Two consecutive loads (0x10 then 0x14) plus a non-memory instruction -> exactly two requests in order. The non-memory instruction adds no stall cycles.
